// File: rtl/alu_cmd_driver_if.sv
// ---------------------------------------------------------------------------
// alu_cmd_driver_if
// Bundles the three buses around alu_cmd_driver:
//   cmd_*  : command channel (valid/ready) from the command source
//   alu_*  : registered operands/opcode out to the ALU, result/flags back
//   rsp_*  : response channel (valid/ready) to the consumer, plus op_count
// Modports:
//   slave  : the driver's view (accepts commands, produces responses)
//   master : the environment's view (command source, ALU and consumer)
// ---------------------------------------------------------------------------
interface alu_cmd_driver_if #(
    parameter int COUNT_W = 16
);
    // command channel
    logic               cmd_valid;
    logic               cmd_ready;
    logic [3:0]         cmd_a;
    logic [3:0]         cmd_b;
    logic [2:0]         cmd_op;
    // ALU side
    logic [3:0]         alu_a;
    logic [3:0]         alu_b;
    logic [2:0]         alu_opcode;
    logic [7:0]         alu_result;
    logic               alu_zero;
    logic               alu_carry;
    // response channel
    logic               rsp_valid;
    logic               rsp_ready;
    logic [7:0]         rsp_result;
    logic               rsp_zero;
    logic               rsp_carry;
    logic               rsp_divzero;
    logic               rsp_illegal;
    logic [COUNT_W-1:0] op_count;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op,
        output cmd_ready,
        output alu_a, alu_b, alu_opcode,
        input  alu_result, alu_zero, alu_carry,
        output rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_divzero, rsp_illegal,
        input  rsp_ready,
        output op_count
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op,
        input  cmd_ready,
        input  alu_a, alu_b, alu_opcode,
        output alu_result, alu_zero, alu_carry,
        input  rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_divzero, rsp_illegal,
        output rsp_ready,
        input  op_count
    );
endinterface

// File: rtl/alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// alu_cmd_driver
// Initiator-side front end for the 4-bit combinational ALU. Takes one command
// at a time, holds its operands on the ALU for SETTLE_CYCLES edges, samples
// the result and flags, and presents them as a response until consumed.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : alu_cmd_driver_if.slave (cmd_*, alu_*, rsp_*, op_count)
// Parameters:
//   SETTLE_CYCLES : edges the operands are held before sampling (1..15)
//   COUNT_W       : width of the wrapping completed-response counter; must
//                   match the COUNT_W of the connected interface
// ---------------------------------------------------------------------------
module alu_cmd_driver #(
    parameter int SETTLE_CYCLES = 1,
    parameter int COUNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_cmd_driver_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_t;

    // The counter is loaded with SETTLE_CYCLES-1 so that sampling happens on
    // the SETTLE_CYCLES-th edge after the accept edge.
    localparam logic [3:0] LP_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t             r_state;
    logic [3:0]         r_settle_cnt;
    logic [3:0]         r_alu_a;
    logic [3:0]         r_alu_b;
    logic [2:0]         r_alu_opcode;
    logic               r_divzero;
    logic               r_illegal;
    logic               r_rsp_valid;
    logic [7:0]         r_rsp_result;
    logic               r_rsp_zero;
    logic               r_rsp_carry;
    logic               r_rsp_divzero;
    logic               r_rsp_illegal;
    logic [COUNT_W-1:0] r_op_count;

    logic               w_cmd_ready;

    // Ready is a pure decode of state so a command can never be taken while
    // an operation is in flight.
    assign w_cmd_ready    = (r_state == IDLE);

    assign bus.cmd_ready   = w_cmd_ready;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_opcode  = r_alu_opcode;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_result  = r_rsp_result;
    assign bus.rsp_zero    = r_rsp_zero;
    assign bus.rsp_carry   = r_rsp_carry;
    assign bus.rsp_divzero = r_rsp_divzero;
    assign bus.rsp_illegal = r_rsp_illegal;
    assign bus.op_count    = r_op_count;

    // NOTE: every register here, datapath included, is reset so an aborted
    // operation leaves no stale operands on the ALU and no stale response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_settle_cnt  <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_opcode  <= '0;
            r_divzero     <= 1'b0;
            r_illegal     <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_zero    <= 1'b0;
            r_rsp_carry   <= 1'b0;
            r_rsp_divzero <= 1'b0;
            r_rsp_illegal <= 1'b0;
            r_op_count    <= '0;
        end else begin
            // NOTE: non-blocking assignments only, so every branch below sees
            // the pre-edge values of all state regardless of statement order.
            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        r_alu_a      <= bus.cmd_a;
                        r_alu_b      <= bus.cmd_b;
                        r_alu_opcode <= bus.cmd_op;
                        r_divzero    <= (bus.cmd_op == 3'b011) && (bus.cmd_b == 4'd0);
                        r_illegal    <= (bus.cmd_op > 3'b011);
                        r_settle_cnt <= LP_SETTLE_LOAD;
                        r_state      <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (r_settle_cnt == 4'd0) begin
                        // ALU output is captured untouched, illegal ops included.
                        r_rsp_result  <= bus.alu_result;
                        r_rsp_zero    <= bus.alu_zero;
                        r_rsp_carry   <= bus.alu_carry;
                        r_rsp_divzero <= r_divzero;
                        r_rsp_illegal <= r_illegal;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end

                RESP: begin
                    // rsp_* are left alone so they read the last response
                    // after the handshake as well as during backpressure.
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_op_count  <= r_op_count + COUNT_W'(1);
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_driver
// Two driver instances share one clock:
//   unit 0 : SETTLE_CYCLES=1, COUNT_W=2  (latency-1 ops, counter wrap)
//   unit 1 : SETTLE_CYCLES=3, COUNT_W=16 (long settle, backpressure, reset)
// Each unit talks to a behavioural 4-bit ALU and is shadowed by a
// transaction-level model (busy flag, edge age since accept, expected
// response). A negedge process compares every output of both units against
// the models each cycle; directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_alu_cmd_driver;
    localparam int S_A = 1;
    localparam int W_A = 2;
    localparam int S_B = 3;
    localparam int W_B = 16;

    typedef struct {
        bit         busy;
        bit         rv;
        int         age;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [7:0] res;
        logic       zero;
        logic       carry;
        logic       dz;
        logic       ill;
        int         count;
        int         acc_cnt;
    } model_t;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;

    logic       cv  [2];
    logic [3:0] ca  [2];
    logic [3:0] cb  [2];
    logic [2:0] cop [2];
    logic       rr  [2];

    logic        rdy_o [2];
    logic        rv_o  [2];
    logic [3:0]  aa_o  [2];
    logic [3:0]  ab_o  [2];
    logic [2:0]  aop_o [2];
    logic [7:0]  res_o [2];
    logic        z_o   [2];
    logic        c_o   [2];
    logic        dz_o  [2];
    logic        il_o  [2];
    logic [15:0] oc_o  [2];

    int n_vec  = 0;
    int n_miss = 0;

    model_t m0;
    model_t m1;

    always #5 clk = ~clk;

    alu_cmd_driver_if #(.COUNT_W(W_A)) if_a ();
    alu_cmd_driver_if #(.COUNT_W(W_B)) if_b ();

    alu_cmd_driver #(.SETTLE_CYCLES(S_A), .COUNT_W(W_A)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (if_a.slave)
    );

    alu_cmd_driver #(.SETTLE_CYCLES(S_B), .COUNT_W(W_B)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (if_b.slave)
    );

    // Behavioural ALU: returns {carry, result}.
    function automatic logic [8:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] op);
        int ia;
        int ib;
        int r;
        logic c;
        ia = int'(a);
        ib = int'(b);
        c  = 1'b0;
        case (op)
            3'd0: begin r = ia + ib; c = (r > 15); end
            3'd1: r = (ia - ib) & 8'hFF;
            3'd2: r = ia * ib;
            3'd3: r = (ib == 0) ? 0 : ia / ib;
            default: r = 0;
        endcase
        return {c, 8'(r)};
    endfunction

    logic [8:0] alu_y0;
    logic [8:0] alu_y1;
    assign alu_y0 = alu_fn(if_a.alu_a, if_a.alu_b, if_a.alu_opcode);
    assign alu_y1 = alu_fn(if_b.alu_a, if_b.alu_b, if_b.alu_opcode);
    assign if_a.alu_result = alu_y0[7:0];
    assign if_a.alu_carry  = alu_y0[8];
    assign if_a.alu_zero   = (alu_y0[7:0] == 8'd0);
    assign if_b.alu_result = alu_y1[7:0];
    assign if_b.alu_carry  = alu_y1[8];
    assign if_b.alu_zero   = (alu_y1[7:0] == 8'd0);

    assign if_a.cmd_valid = cv[0];
    assign if_a.cmd_a     = ca[0];
    assign if_a.cmd_b     = cb[0];
    assign if_a.cmd_op    = cop[0];
    assign if_a.rsp_ready = rr[0];
    assign if_b.cmd_valid = cv[1];
    assign if_b.cmd_a     = ca[1];
    assign if_b.cmd_b     = cb[1];
    assign if_b.cmd_op    = cop[1];
    assign if_b.rsp_ready = rr[1];

    assign rdy_o[0] = if_a.cmd_ready;    assign rdy_o[1] = if_b.cmd_ready;
    assign rv_o[0]  = if_a.rsp_valid;    assign rv_o[1]  = if_b.rsp_valid;
    assign aa_o[0]  = if_a.alu_a;        assign aa_o[1]  = if_b.alu_a;
    assign ab_o[0]  = if_a.alu_b;        assign ab_o[1]  = if_b.alu_b;
    assign aop_o[0] = if_a.alu_opcode;   assign aop_o[1] = if_b.alu_opcode;
    assign res_o[0] = if_a.rsp_result;   assign res_o[1] = if_b.rsp_result;
    assign z_o[0]   = if_a.rsp_zero;     assign z_o[1]   = if_b.rsp_zero;
    assign c_o[0]   = if_a.rsp_carry;    assign c_o[1]   = if_b.rsp_carry;
    assign dz_o[0]  = if_a.rsp_divzero;  assign dz_o[1]  = if_b.rsp_divzero;
    assign il_o[0]  = if_a.rsp_illegal;  assign il_o[1]  = if_b.rsp_illegal;
    assign oc_o[0]  = 16'(if_a.op_count);
    assign oc_o[1]  = if_b.op_count;

    // ---------------- reference model ----------------
    function automatic model_t model_reset();
        model_t m;
        m.busy = 0; m.rv = 0; m.age = 0;
        m.a = '0; m.b = '0; m.op = '0;
        m.res = '0; m.zero = 0; m.carry = 0; m.dz = 0; m.ill = 0;
        m.count = 0; m.acc_cnt = 0;
        return m;
    endfunction

    // One clock edge of a unit: accept when idle, respond once the operation
    // has aged SETTLE_CYCLES edges, retire on the response handshake.
    function automatic model_t model_step(input model_t m, input int s, input int w,
                                          input logic v, input logic [3:0] a,
                                          input logic [3:0] b, input logic [2:0] op,
                                          input logic ready);
        model_t n;
        logic [8:0] y;
        n = m;
        if (!m.busy) begin
            if (v) begin
                n.busy = 1; n.age = 1;
                n.a = a; n.b = b; n.op = op;
                n.acc_cnt = m.acc_cnt + 1;
            end
        end else if (!m.rv) begin
            if (m.age == s) begin
                y       = alu_fn(m.a, m.b, m.op);
                n.rv    = 1;
                n.res   = y[7:0];
                n.carry = y[8];
                n.zero  = (y[7:0] == 8'd0);
                n.dz    = (m.op == 3'd3) && (m.b == 4'd0);
                n.ill   = (m.op > 3'd3);
            end else begin
                n.age = m.age + 1;
            end
        end else if (ready) begin
            n.rv    = 0;
            n.busy  = 0;
            n.count = (m.count + 1) % (1 << w);
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst_a) begin
        if (rst_a) m0 <= model_reset();
        else       m0 <= model_step(m0, S_A, W_A, cv[0], ca[0], cb[0], cop[0], rr[0]);
    end

    always @(posedge clk or posedge rst_b) begin
        if (rst_b) m1 <= model_reset();
        else       m1 <= model_step(m1, S_B, W_B, cv[1], ca[1], cb[1], cop[1], rr[1]);
    end

    function automatic model_t get_m(input int u);
        if (u == 0) return m0;
        return m1;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input int u, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s unit%0d: got 0x%0h, want 0x%0h (t=%0t)", name, u, act, exp, $time);
        end
    endtask

    task automatic compare_unit(input int u);
        model_t m;
        m = get_m(u);
        check("cmd_ready",   u, 32'(rdy_o[u]), 32'(!m.busy));
        check("rsp_valid",   u, 32'(rv_o[u]),  32'(m.rv));
        check("alu_a",       u, 32'(aa_o[u]),  32'(m.a));
        check("alu_b",       u, 32'(ab_o[u]),  32'(m.b));
        check("alu_opcode",  u, 32'(aop_o[u]), 32'(m.op));
        check("rsp_result",  u, 32'(res_o[u]), 32'(m.res));
        check("rsp_zero",    u, 32'(z_o[u]),   32'(m.zero));
        check("rsp_carry",   u, 32'(c_o[u]),   32'(m.carry));
        check("rsp_divzero", u, 32'(dz_o[u]),  32'(m.dz));
        check("rsp_illegal", u, 32'(il_o[u]),  32'(m.ill));
        check("op_count",    u, 32'(oc_o[u]),  32'(m.count));
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) compare_unit(u);
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; returns at the negedge just after the response
    // handshake edge. lat = edges from accept to rsp_valid as seen on the DUT.
    task automatic run_op(input int u, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] op, input int stall, input bit noise,
                          input int chk_res, output int lat);
        int start;
        int n;
        start = get_m(u).acc_cnt;
        cv[u] = 1'b1; ca[u] = a; cb[u] = b; cop[u] = op; rr[u] = 1'b0;
        n = 0;
        while (get_m(u).acc_cnt == start && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) check("accept timeout", u, 32'd0, 32'd1);
        cv[u] = 1'b0;
        lat = -1;
        n = 0;
        while (n < 64) begin
            if (rv_o[u] && lat < 0) lat = n;
            if (get_m(u).rv) break;
            check("ready low in settle", u, 32'(rdy_o[u]), 32'd0);
            cv[u]  = noise ? 1'($urandom) : 1'b0;
            ca[u]  = 4'($urandom);
            cb[u]  = 4'($urandom);
            cop[u] = 3'($urandom);
            rr[u]  = noise ? 1'($urandom) : 1'b0;
            @(negedge clk);
            n++;
        end
        if (n >= 64) check("response timeout", u, 32'd0, 32'd1);
        for (int i = 0; i < stall; i++) begin
            rr[u] = 1'b0;
            cv[u] = noise ? 1'($urandom) : 1'b0;
            cop[u] = 3'($urandom);
            @(negedge clk);
            check("ready low in stall", u, 32'(rdy_o[u]), 32'd0);
            check("valid held in stall", u, 32'(rv_o[u]), 32'd1);
            if (chk_res >= 0) check("result held in stall", u, 32'(res_o[u]), 32'(chk_res));
        end
        cv[u] = 1'b0;
        rr[u] = 1'b1;
        @(negedge clk);
        rr[u] = 1'b0;
    endtask

    task automatic pulse_reset(input int u);
        if (u == 0) rst_a = 1'b1; else rst_b = 1'b1;
        @(negedge clk);
        if (u == 0) rst_a = 1'b0; else rst_b = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int start;
        int seq [5];
        seq = '{1, 2, 3, 0, 1};
        for (int u = 0; u < 2; u++) begin
            cv[u] = 1'b0; ca[u] = '0; cb[u] = '0; cop[u] = '0; rr[u] = 1'b0;
        end
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("reset cmd_ready", u, 32'(rdy_o[u]), 32'd1);
            check("reset rsp_valid", u, 32'(rv_o[u]), 32'd0);
            check("reset alu_a",     u, 32'(aa_o[u]), 32'd0);
            check("reset op_count",  u, 32'(oc_o[u]), 32'd0);
        end

        // add with carry out, latency 1
        run_op(0, 4'd15, 4'd1, 3'd0, 0, 0, -1, lat);
        check("lat S=1",      0, 32'(lat), 32'd1);
        check("add result",   0, 32'(res_o[0]), 32'h10);
        check("add zero",     0, 32'(z_o[0]), 32'd0);
        check("add carry",    0, 32'(c_o[0]), 32'd1);
        check("add divzero",  0, 32'(dz_o[0]), 32'd0);
        check("add illegal",  0, 32'(il_o[0]), 32'd0);
        check("add op_count", 0, 32'(oc_o[0]), 32'd1);

        // sub then mul
        pulse_reset(0);
        run_op(0, 4'd3, 4'd5, 3'd1, 1, 0, -1, lat);
        check("sub result", 0, 32'(res_o[0]), 32'hFE);
        check("sub carry",  0, 32'(c_o[0]), 32'd0);
        run_op(0, 4'd15, 4'd15, 3'd2, 0, 0, -1, lat);
        check("mul result",   0, 32'(res_o[0]), 32'hE1);
        check("mul carry",    0, 32'(c_o[0]), 32'd0);
        check("mul op_count", 0, 32'(oc_o[0]), 32'd2);

        // divide by zero, then an illegal opcode
        run_op(0, 4'd7, 4'd0, 3'd3, 0, 0, -1, lat);
        check("div0 result",  0, 32'(res_o[0]), 32'h00);
        check("div0 zero",    0, 32'(z_o[0]), 32'd1);
        check("div0 divzero", 0, 32'(dz_o[0]), 32'd1);
        run_op(0, 4'd6, 4'd0, 3'd5, 0, 0, -1, lat);
        check("ill result",  0, 32'(res_o[0]), 32'h00);
        check("ill zero",    0, 32'(z_o[0]), 32'd1);
        check("ill illegal", 0, 32'(il_o[0]), 32'd1);
        check("ill divzero", 0, 32'(dz_o[0]), 32'd0);

        // reset one cycle into SETTLE aborts the op
        start = m1.acc_cnt;
        cv[1] = 1'b1; ca[1] = 4'd9; cb[1] = 4'd2; cop[1] = 3'd3;
        @(negedge clk);
        check("abort accept", 1, 32'(m1.acc_cnt), 32'(start + 1));
        cv[1] = 1'b0;
        @(negedge clk);
        #2;
        rst_b = 1'b1;
        #1;
        check("abort rsp_valid",  1, 32'(rv_o[1]), 32'd0);
        check("abort alu_a",      1, 32'(aa_o[1]), 32'd0);
        check("abort alu_b",      1, 32'(ab_o[1]), 32'd0);
        check("abort alu_opcode", 1, 32'(aop_o[1]), 32'd0);
        check("abort op_count",   1, 32'(oc_o[1]), 32'd0);
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        check("post-abort ready", 1, 32'(rdy_o[1]), 32'd1);
        run_op(1, 4'd8, 4'd3, 3'd0, 0, 0, 32'h0B, lat);
        check("post-abort result",   1, 32'(res_o[1]), 32'h0B);
        check("post-abort op_count", 1, 32'(oc_o[1]), 32'd1);

        // long settle with backpressure and ignored command pulses
        run_op(1, 4'd9, 4'd2, 3'd3, 5, 1, 32'h04, lat);
        check("lat S=3",       1, 32'(lat), 32'd3);
        check("stall result",  1, 32'(res_o[1]), 32'h04);
        check("stall op_count",1, 32'(oc_o[1]), 32'd2);

        // counter wrap on a 2-bit counter
        pulse_reset(0);
        for (int i = 0; i < 5; i++) begin
            run_op(0, 4'($urandom), 4'($urandom), 3'd0, 0, 0, -1, lat);
            check("wrap op_count", 0, 32'(oc_o[0]), 32'(seq[i]));
        end

        // random traffic on both units (compare process does the checking)
        for (int i = 0; i < 40; i++) begin
            for (int u = 0; u < 2; u++) begin
                run_op(u, 4'($urandom), 4'($urandom), 3'($urandom_range(0, 7)),
                       $urandom_range(0, 3), 1'b1, -1, lat);
            end
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
Initiator-side front end for the team's combinational 4-bit ALU. It accepts operation commands over a valid/ready interface and drives registered operands and opcode onto the ALU inputs. After a programmable settle time it samples the ALU result and flags, then returns them over a valid/ready response interface. It sits between the command source (sequencer/testbench host) and the ALU instance.

Parameters:
SETTLE_CYCLES, 1, cycles operands are held on the ALU before the result is sampled; legal range 1..15, 0 illegal
COUNT_W, 16, width of completed-operation counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  driver can accept command
cmd_a  input  4  operand A
cmd_b  input  4  operand B
cmd_op  input  3  opcode (000 add, 001 sub, 010 mul, 011 div, others illegal)
alu_a  output  4  registered operand A to ALU
alu_b  output  4  registered operand B to ALU
alu_opcode  output  3  registered opcode to ALU
alu_result  input  8  ALU result
alu_zero  input  1  ALU zero flag
alu_carry  input  1  ALU carry flag
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  8  captured result
rsp_zero  output  1  captured zero flag
rsp_carry  output  1  captured carry flag
rsp_divzero  output  1  op was div with B==0
rsp_illegal  output  1  opcode outside 000..011
op_count  output  COUNT_W  completed responses, wraps

Behaviour:
- Reset (async assert, sync release): state IDLE; cmd_ready=1 after release; rsp_valid=0; all rsp_* =0; alu_a/alu_b/alu_opcode=0; op_count=0; settle counter=0.
- States: IDLE, SETTLE, RESP. cmd_ready=1 only in IDLE (combinational from state); rsp_valid=1 only in RESP (registered).
- IDLE: on a cmd_valid&&cmd_ready edge, latch cmd_a/b/op into alu_a/b/opcode, compute divzero=(op==011 && b==0) and illegal=(op>011), load settle counter with SETTLE_CYCLES-1, go to SETTLE.
- SETTLE: alu_* held constant. On each edge, if counter==0, capture alu_result/alu_zero/alu_carry plus latched divzero/illegal into rsp_*, then go to RESP; otherwise decrement.
- Latency: command accepted at edge N, rsp_valid high after edge N+SETTLE_CYCLES. With SETTLE_CYCLES=1 that is the next edge.
- RESP: rsp_* stable while rsp_valid && !rsp_ready (no change under backpressure). On the rsp_valid&&rsp_ready edge: op_count+=1 (mod 2^COUNT_W), go to IDLE, rsp_valid=0. rsp_* keep their last values.
- No overlap: a new command is not accepted until the cycle after the response handshake. Maximum throughput is one op per SETTLE_CYCLES+2 cycles.
- alu_* outputs hold the last command until the next accept.
- Illegal opcodes are still driven to the ALU, and its result (expected 0) is captured as is.
- The driver never alters ALU arithmetic; widths are passed straight through.
- cmd_* are ignored when cmd_ready=0. rsp_ready is ignored when rsp_valid=0.
- Reset mid-SETTLE or mid-RESP aborts the op. No response is produced and op_count is not incremented.

Test Plan:
- SETTLE_CYCLES=1, cmd a=15,b=1,op=000, rsp_ready=1 -> rsp_valid 1 cycle after accept; result=0x10, zero=0, carry=1, divzero=0, illegal=0; op_count=1.
- cmd a=3,b=5,op=001, then a=15,b=15,op=010 -> results 0xFE then 0xE1, carry=0 both; cmd_ready low from accept through the response handshake; op_count=2.
- cmd a=7,b=0,op=011 -> result=0x00, zero=1, divzero=1; then a=6,b=0,op=101 -> result=0x00, zero=1, illegal=1, divzero=0.
- SETTLE_CYCLES=3, a=9,b=2,op=011, rsp_ready held low 5 cycles after rsp_valid -> rsp_valid exactly 3 edges after accept; result=0x04 stable for all stall cycles; cmd_valid pulses during the stall are ignored.
- SETTLE_CYCLES=3, assert rst one cycle into SETTLE -> immediately rsp_valid=0, alu_*=0, op_count unchanged (0); after release cmd_ready=1 and the next command completes normally.
- COUNT_W=2, run 5 back-to-back ops with rsp_ready=1 -> op_count sequence 1,2,3,0,1.
